// File: rtl/scope_capture_buffer.sv
// Triggered multi-channel capture buffer: circular writes into a dual-port RAM,
// programmable pre-trigger history, freeze on completion, trigger-relative readout.
module scope_capture_buffer #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_arm,
    input  logic                           i_abort,
    input  logic [ADDR_WIDTH-1:0]          i_pretrig,
    input  logic                           i_sample_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   i_sample,
    input  logic                           i_trig,
    input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_rd_data,
    output logic                           o_busy,
    output logic                           o_armed,
    output logic                           o_done,
    output logic [ADDR_WIDTH-1:0]          o_trig_addr
);

    localparam int unsigned SW = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPretrig,
        StArmed,
        StPosttrig,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pre_q, pre_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [ADDR_WIDTH:0]   post_len;
    logic [SW-1:0]         rd_data_q;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  capturing;
    logic                  wr_en;

    logic [SW-1:0] mem [DEPTH];

    assign capturing = (state_q == StPretrig) || (state_q == StArmed) || (state_q == StPosttrig);
    assign wr_en     = capturing && i_sample_valid;
    assign cnt_inc   = cnt_q + CNT_ONE;
    // Samples kept from the trigger onwards, trigger sample included.
    assign post_len  = DEPTH_CNT - {1'b0, pre_q};
    // Address 0 of the readout is the oldest retained sample.
    assign rd_ptr    = start_q + i_rd_addr;

    // Next-state logic for the acquisition sequence and its pointers.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        wr_ptr_d    = wr_ptr_q;
        start_d     = start_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;

        case (state_q)
            StIdle, StDone: begin
                if (i_arm) begin
                    pre_d    = i_pretrig;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    state_d  = (i_pretrig != '0) ? StPretrig : StArmed;
                end
            end
            StPretrig: begin
                if (i_sample_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == {1'b0, pre_q}) begin
                        state_d = StArmed;
                    end
                end
            end
            StArmed: begin
                if (i_sample_valid && i_trig) begin
                    trig_addr_d = wr_ptr_q;
                    start_d     = wr_ptr_q - pre_q;
                    cnt_d       = CNT_ONE;
                    // With pre = DEPTH-1 the trigger sample alone completes the buffer.
                    state_d     = (post_len == CNT_ONE) ? StDone : StPosttrig;
                end
            end
            StPosttrig: begin
                if (i_sample_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == post_len) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end

        if (i_abort) begin
            state_d = StIdle;
        end
    end

    // Control registers and registered read port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            pre_q       <= '0;
            wr_ptr_q    <= '0;
            start_q     <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            wr_ptr_q    <= wr_ptr_d;
            start_q     <= start_d;
            trig_addr_q <= trig_addr_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= mem[rd_ptr];
        end
    end

    // Sample RAM write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= i_sample;
        end
    end

    assign o_rd_data   = rd_data_q;
    assign o_busy      = capturing;
    assign o_armed     = (state_q == StArmed);
    assign o_done      = (state_q == StDone);
    assign o_trig_addr = trig_addr_q;

endmodule
